// File: rtl/hash160_pkg.sv
// Shared types and constants for the Hash160 digest output path.
package hash160_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DIGEST_BYTES = 20;
  localparam int RAW_FRAME_LEN = DIGEST_BYTES;
  localparam int HEX_FRAME_LEN = 2 * DIGEST_BYTES;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic int frame_len(input bit hex_mode, input bit append_term);
    return (hex_mode ? HEX_FRAME_LEN : RAW_FRAME_LEN) + (append_term ? 1 : 0);
  endfunction

endpackage

// File: rtl/hash160_byte_serializer_hex.sv
// Maps one 4-bit nibble to its lowercase ASCII hex character.
module hex_nibble_to_ascii
  import hash160_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_ZERO + {4'b0000, nibble};
    else                ascii = ASCII_A_LC + ({4'b0000, nibble} - 8'd10);
  end

endmodule

// File: rtl/hash160_byte_serializer.sv
// Captures a 160-bit digest and streams it MSB-first as raw bytes or hex
// characters over a valid/ready byte interface, with an optional LF terminator.
module hash160_byte_serializer
  import hash160_pkg::*;
#(
  parameter bit HEX_MODE    = 1'b0,
  parameter bit APPEND_TERM = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [159:0] i_digest,
  output logic         o_ready,
  output logic [7:0]   o_byte,
  output logic         o_byte_valid,
  input  logic         i_byte_ready,
  output logic         o_last,
  output logic         o_busy,
  output logic         o_done,
  output state_t       dbg_state
);

  // Byte interface: a byte moves on any cycle where o_byte_valid && i_byte_ready;
  // while i_byte_ready is low, o_byte, o_last and the position hold.
  localparam int N = frame_len(HEX_MODE, APPEND_TERM);
  localparam logic [5:0] LAST_IDX = 6'(N - 1);

  state_t         state_q, state_d;
  logic [159:0]   digest_q;
  logic [5:0]     cnt_q, cnt_d;
  logic           capture;
  logic [159:0]   sel_digest;
  logic [4:0]     byte_idx;
  logic [7:0]     raw_byte;
  logic [3:0]     nibble;
  logic [7:0]     hex_char;
  logic [7:0]     byte_d;
  logic [7:0]     byte_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          capture = 1'b1;
          cnt_d   = 6'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_byte_ready) begin
          if (cnt_q == LAST_IDX) state_d = ST_DONE;
          else                   cnt_d   = cnt_q + 6'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // o_byte is precomputed from the position the next cycle will present.
  assign sel_digest = capture ? i_digest : digest_q;
  assign byte_idx   = HEX_MODE ? cnt_d[5:1] : cnt_d[4:0];

  always_comb begin
    raw_byte = 8'h00;
    for (int i = 0; i < DIGEST_BYTES; i++) begin
      if (byte_idx == 5'(i)) raw_byte = sel_digest[159 - 8*i -: 8];
    end
  end

  assign nibble = cnt_d[0] ? raw_byte[3:0] : raw_byte[7:4];

  hex_nibble_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    if (APPEND_TERM && cnt_d == LAST_IDX) byte_d = ASCII_LF;
    else if (HEX_MODE)                    byte_d = hex_char;
    else                                  byte_d = raw_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      digest_q <= '0;
      byte_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) digest_q <= i_digest;
      byte_q  <= (state_d == ST_SEND) ? byte_d : 8'h00;
    end
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign o_byte_valid = (state_q == ST_SEND);
  assign o_busy       = (state_q == ST_SEND);
  assign o_done       = (state_q == ST_DONE);
  assign o_last       = (state_q == ST_SEND) && (cnt_q == LAST_IDX);
  assign o_byte       = byte_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hash160_byte_serializer.sv
// Directed bench: raw, hex and hex+terminator instances driven in parallel.
module tb_hash160_byte_serializer;
  import hash160_pkg::*;

  localparam logic [159:0] D1   = 160'hb472a266d0bd89c13706a4132ccfb16f7c3b9fcb;
  localparam logic [159:0] ONES = {160{1'b1}};
  localparam logic [159:0] D01  = 160'h1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic [159:0] i_digest = '0;
  logic         i_byte_ready = 1'b0;

  logic         o_ready[3];
  logic [7:0]   o_byte[3];
  logic         o_byte_valid[3];
  logic         o_last[3];
  logic         o_busy[3];
  logic         o_done[3];
  state_t       dbg_state[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hash160_byte_serializer #(
      .HEX_MODE    (g > 0),
      .APPEND_TERM (g == 2)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid      (i_valid),
      .i_digest     (i_digest),
      .o_ready      (o_ready[g]),
      .o_byte       (o_byte[g]),
      .o_byte_valid (o_byte_valid[g]),
      .i_byte_ready (i_byte_ready),
      .o_last       (o_last[g]),
      .o_busy       (o_busy[g]),
      .o_done       (o_done[g]),
      .dbg_state    (dbg_state[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected {last, byte} per instance.
  logic [8:0] exp_q[3][$];
  logic [7:0] log_b[3][64];
  int         n_xfer[3];
  logic       pend_done[3];
  logic       held_v[3];
  logic [8:0] held[3];

  function automatic void push_exp(input int k, input logic [159:0] d);
    string hx = "0123456789abcdef";
    logic [7:0] b;
    for (int i = 0; i < 20; i++) begin
      b = d[159 - 8*i -: 8];
      if (k == 0) begin
        exp_q[k].push_back({i == 19, b});
      end else begin
        exp_q[k].push_back({1'b0, hx[b[7:4]]});
        exp_q[k].push_back({(k == 1) && (i == 19), hx[b[3:0]]});
      end
    end
    if (k == 2) exp_q[k].push_back({1'b1, 8'h0a});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        check("done_pulse", 32'(o_done[k]), 32'(pend_done[k]));
        pend_done[k] = 1'b0;
        if (held_v[k] && o_byte_valid[k])
          check("stall_hold", 32'({o_last[k], o_byte[k]}), 32'(held[k]));
        held_v[k] = 1'b0;
        if (o_byte_valid[k]) begin
          if (i_byte_ready) begin
            if (exp_q[k].size() == 0) check("extra_byte", 32'(exp_q[k].size()), 32'd1);
            else check("byte", 32'({o_last[k], o_byte[k]}), 32'(exp_q[k].pop_front()));
            if (n_xfer[k] < 64) log_b[k][n_xfer[k]] = o_byte[k];
            n_xfer[k]++;
            if (o_last[k]) pend_done[k] = 1'b1;
          end else begin
            held_v[k] = 1'b1;
            held[k]   = {o_last[k], o_byte[k]};
          end
        end
      end
    end
  end

  task automatic clear_sb();
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      n_xfer[k]    = 0;
      pend_done[k] = 1'b0;
      held_v[k]    = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_ready"}, 32'(o_ready[k]), 32'd1);
      check({tag, "_byte"},  32'(o_byte[k]), 32'd0);
      check({tag, "_valid"}, 32'(o_byte_valid[k]), 32'd0);
      check({tag, "_last"},  32'(o_last[k]), 32'd0);
      check({tag, "_busy"},  32'(o_busy[k]), 32'd0);
      check({tag, "_done"},  32'(o_done[k]), 32'd0);
    end
  endtask

  task automatic start_frame(input logic [159:0] d);
    for (int k = 0; k < 3; k++) begin
      push_exp(k, d);
      n_xfer[k] = 0;
    end
    @(posedge clk); #1;
    i_valid = 1'b1; i_digest = d;
    @(posedge clk); #1;
    i_valid = 1'b0; i_digest = {5{$urandom}};
  endtask

  // Runs until every instance is back in IDLE with its queue drained.
  task automatic wait_frames(input bit stall);
    int cyc = 0;
    bit all_idle = 1'b0;
    while (!all_idle && cyc < 400) begin
      if (stall) i_byte_ready = (cyc % 4 == 0 || cyc % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1) & (cyc % 7 == 0));
      else       i_byte_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
      all_idle = 1'b1;
      for (int k = 0; k < 3; k++)
        if (!o_ready[k] || exp_q[k].size() != 0) all_idle = 1'b0;
    end
    check("frame_timeout", 32'(cyc < 400), 32'd1);
    i_byte_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    clear_sb();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Raw, hex and hex+LF of the reference digest, sink always ready.
    start_frame(D1);
    wait_frames(1'b0);
    check("raw_len", 32'(n_xfer[0]), 32'd20);
    check("raw_b0",  32'(log_b[0][0]), 32'hb4);
    check("raw_b1",  32'(log_b[0][1]), 32'h72);
    check("raw_b19", 32'(log_b[0][19]), 32'hcb);
    check("hex_len", 32'(n_xfer[1]), 32'd40);
    check("hex_c0",  32'(log_b[1][0]), 32'h62);
    check("hex_c1",  32'(log_b[1][1]), 32'h34);
    check("hex_c2",  32'(log_b[1][2]), 32'h37);
    check("hex_c38", 32'(log_b[1][38]), 32'h63);
    check("hex_c39", 32'(log_b[1][39]), 32'h62);
    check("term_len", 32'(n_xfer[2]), 32'd41);
    check("term_lf", 32'(log_b[2][40]), 32'h0a);
    for (int k = 0; k < 3; k++) check("idle_state", 32'(dbg_state[k]), 32'(ST_IDLE));

    // All-ones digest.
    start_frame(ONES);
    wait_frames(1'b0);
    check("ones_raw0", 32'(log_b[0][0]), 32'hff);
    check("ones_hex0", 32'(log_b[2][0]), 32'h66);
    check("ones_hex39", 32'(log_b[2][39]), 32'h66);
    check("ones_lf", 32'(log_b[2][40]), 32'h0a);
    check("ones_len", 32'(n_xfer[2]), 32'd41);

    // Backpressure.
    start_frame(D1);
    wait_frames(1'b1);
    check("stall_len", 32'(n_xfer[0]), 32'd20);
    check("stall_b19", 32'(log_b[0][19]), 32'hcb);
    check("stall_hexlen", 32'(n_xfer[1]), 32'd40);

    // i_valid during SEND is ignored, then a fresh frame of 0..01.
    start_frame(D1);
    i_byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_valid = 1'b1; i_digest = D01;
    @(posedge clk); #1;
    i_valid = 1'b0;
    wait_frames(1'b0);
    check("ign_b0",  32'(log_b[0][0]), 32'hb4);
    check("ign_b19", 32'(log_b[0][19]), 32'hcb);
    start_frame(D01);
    wait_frames(1'b0);
    check("d01_b0",  32'(log_b[0][0]), 32'h00);
    check("d01_b18", 32'(log_b[0][18]), 32'h00);
    check("d01_b19", 32'(log_b[0][19]), 32'h01);
    check("d01_h38", 32'(log_b[1][38]), 32'h30);
    check("d01_h39", 32'(log_b[1][39]), 32'h31);

    // Asynchronous reset after byte 7, then a clean restart.
    start_frame(D1);
    i_byte_ready = 1'b1;
    cyc = 0;
    while (n_xfer[0] < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_wait", 32'(cyc < 100), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("abort");
    clear_sb();
    i_byte_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("abort_hold");
    rst_n = 1'b1;
    start_frame(D1);
    wait_frames(1'b0);
    check("restart_len", 32'(n_xfer[0]), 32'd20);
    check("restart_b0",  32'(log_b[0][0]), 32'hb4);
    check("restart_b19", 32'(log_b[0][19]), 32'hcb);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
